// File: rtl/sha_result_join.sv
// sha_result_join
//   Joins the SHA descriptor, the Keccak digest and the payload bypass stream
//   into one AXI-Stream packet. The first beat is a header
//   {zeros, digest[DIGEST_WIDTH-1:0], descriptor}. The payload beats follow
//   unchanged. Payloads longer than MAX_BEATS are cut at MAX_BEATS: tlast is
//   forced on the last kept beat, and the remaining input beats are dropped.
//
// Ports
//   clk, rst             single clock; asynchronous active-high reset
//   s_desc_*             descriptor stream (tdata/tvalid/tready)
//   s_sha_*              512-bit digest stream (tdata/tvalid/tready)
//   s_data_*             payload bypass stream (tdata/tkeep/tlast/tvalid/tready)
//   m_axis_*             joined output packet (tdata/tkeep/tlast/tvalid/tready)
//   pkt_cnt              packets that completed normally (wraps)
//   err_cnt              oversize packets that were truncated (saturates)
//
// Handshake: a beat moves on a rising edge when tvalid and tready are both
// high. Once tvalid is raised, the source holds tvalid and its data stable
// until that edge. This block raises a ready combinationally from a valid in
// two places only. The first is IDLE: the descriptor and digest are accepted
// together, and only when both are valid. The second is the PAYLOAD
// passthrough.

module sha_result_join #(
  parameter int DATA_WIDTH   = 512,
  parameter int DESC_WIDTH   = 128,
  parameter int DIGEST_WIDTH = 256,
  parameter int MAX_BEATS    = 64,
  localparam int KEEP_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DESC_WIDTH-1:0] s_desc_tdata,
  input  logic                  s_desc_tvalid,
  output logic                  s_desc_tready,
  input  logic [511:0]          s_sha_tdata,
  input  logic                  s_sha_tvalid,
  output logic                  s_sha_tready,
  input  logic [DATA_WIDTH-1:0] s_data_tdata,
  input  logic [KEEP_WIDTH-1:0] s_data_tkeep,
  input  logic                  s_data_tvalid,
  input  logic                  s_data_tlast,
  output logic                  s_data_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [31:0]           pkt_cnt,
  output logic [15:0]           err_cnt
);

  localparam int BCW   = $clog2(MAX_BEATS + 1);
  localparam int HDR_W = DESC_WIDTH + DIGEST_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [HDR_W-1:0] hdr_q, hdr_d;
  logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [31:0]      pkt_cnt_q, pkt_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             both_valid;
  logic             at_max;

  // The digest bits above DIGEST_WIDTH never reach the header.
  generate
    if (DIGEST_WIDTH < 512) begin : g_sha_unused
      logic sha_hi_unused;
      assign sha_hi_unused = ^s_sha_tdata[511:DIGEST_WIDTH];
    end
  endgenerate

  always_comb begin
    both_valid    = s_desc_tvalid && s_sha_tvalid;
    // The beat currently offered would be the MAX_BEATS-th beat of the payload.
    at_max        = (beat_cnt_q == BCW'(MAX_BEATS - 1));

    s_desc_tready = 1'b0;
    s_sha_tready  = 1'b0;
    s_data_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;

    state_d       = state_q;
    hdr_d         = hdr_q;
    beat_cnt_d    = beat_cnt_q;
    pkt_cnt_d     = pkt_cnt_q;
    err_cnt_d     = err_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // Accept the descriptor and digest together, and only when both are valid.
        // Gating with rst keeps both readies low for the whole reset.
        s_desc_tready = both_valid && !rst;
        s_sha_tready  = both_valid && !rst;
        if (both_valid) begin
          hdr_d   = {s_sha_tdata[DIGEST_WIDTH-1:0], s_desc_tdata};
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = DATA_WIDTH'(hdr_q);
        m_axis_tkeep  = '1;
        if (m_axis_tready) begin
          beat_cnt_d = '0;
          state_d    = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        m_axis_tvalid = s_data_tvalid;
        s_data_tready = m_axis_tready;
        m_axis_tdata  = s_data_tdata;
        m_axis_tkeep  = s_data_tkeep;
        m_axis_tlast  = s_data_tlast || at_max;
        if (s_data_tvalid && m_axis_tready) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (s_data_tlast) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            state_d   = ST_IDLE;
          end else if (at_max) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Accept and drop the rest of the oversize payload, up to its tlast.
        s_data_tready = 1'b1;
        if (s_data_tvalid && s_data_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hdr_q      <= '0;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule
